detector_jogada: RTL and testbench

- Upstream stage of the memory-game datapath. Conditions the raw 4-bit player switches into a single clean "play" event.
- Synchronizes and debounces the switches, validates that exactly one key is pressed, registers the key code, and emits a one-cycle jogada_feita pulse.
- The controller/datapath consumes that pulse and the code to compare against memory.
- A new play is only accepted after all keys have been released and stable.

---
 rtl/detector_jogada.sv | 94 +++++++++
 tb/tb_detector_jogada.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/detector_jogada.sv
// Turns the raw player switches into one clean play event: synchronize, debounce,
// check for exactly one key, latch the code and pulse jogada_feita (or invalida).
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] chaves,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       invalida,
    output logic [3:0] db_estado
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] OCIOSO         = 2'd0;
    localparam logic [1:0] FILTRANDO      = 2'd1;
    localparam logic [1:0] DETECTADO      = 2'd2;
    localparam logic [1:0] AGUARDA_SOLTAR = 2'd3;

    logic [3:0]    sinc_ff;
    logic [3:0]    sinc;
    logic [3:0]    amostra;
    logic [CW-1:0] cont;
    logic [1:0]    estado;
    logic          um_quente;

    assign um_quente = (amostra != 4'd0) && ((amostra & (amostra - 4'd1)) == 4'd0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            sinc_ff <= 4'd0;
            sinc    <= 4'd0;
        end else begin
            sinc_ff <= chaves;
            sinc    <= sinc_ff;
        end
    end

    // Reset parks the FSM in AGUARDA_SOLTAR so a key held through reset must be released first.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado  <= AGUARDA_SOLTAR;
            amostra <= 4'd0;
            cont    <= '0;
            jogada  <= 4'd0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (sinc != 4'd0 && enable) begin
                        amostra <= sinc;
                        cont    <= '0;
                        estado  <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (sinc == 4'd0) begin
                        estado <= OCIOSO;
                    end else if (sinc != amostra) begin
                        amostra <= sinc;
                        cont    <= '0;
                    end else if (cont == CONT_MAX) begin
                        estado <= DETECTADO;
                        if (um_quente)
                            jogada <= amostra;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
                DETECTADO: begin
                    cont   <= '0;
                    estado <= AGUARDA_SOLTAR;
                end
                default: begin
                    if (sinc != 4'd0) begin
                        cont <= '0;
                    end else if (cont == CONT_MAX) begin
                        estado <= OCIOSO;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
            endcase
        end
    end

    assign jogada_feita = (estado == DETECTADO) &&  um_quente;
    assign invalida     = (estado == DETECTADO) && !um_quente;
    assign db_estado    = {2'b00, estado};

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CYCLES=4: segment table plus exact-timing sequences.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] chaves;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       invalida;
    logic [3:0] db_estado;

    int nvec = 0;
    int nerr = 0;

    detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .chaves       (chaves),
        .jogada_feita (jogada_feita),
        .jogada       (jogada),
        .invalida     (invalida),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] ch;
        int         n;
        int         feita;
        int         inv;
        logic [3:0] jog;
        logic [3:0] est;
    } vec_t;

    vec_t tab[17];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int cycles, output int nf, output int ni);
        nf = 0;
        ni = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (jogada_feita === 1'b1) nf++;
            if (invalida === 1'b1) ni++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nf, ni;
        reset  = 1'b0;
        enable = 1'b0;
        chaves = 4'd0;

        //          rst   en    chaves   n   feita inv jogada estado
        tab[0]  = '{1'b0, 1'b0, 4'b0000, 2,   0, 0, 4'h0, 4'h3};
        tab[1]  = '{1'b1, 1'b0, 4'b0000, 4,   0, 0, 4'h0, 4'h0};
        tab[2]  = '{1'b1, 1'b1, 4'b0100, 20,  1, 0, 4'h4, 4'h3};
        tab[3]  = '{1'b1, 1'b1, 4'b0000, 8,   0, 0, 4'h4, 4'h0};
        tab[4]  = '{1'b1, 1'b1, 4'b0001, 20,  1, 0, 4'h1, 4'h3};
        tab[5]  = '{1'b1, 1'b1, 4'b0000, 8,   0, 0, 4'h1, 4'h0};
        tab[6]  = '{1'b1, 1'b1, 4'b0010, 2,   0, 0, 4'h1, 4'h0};
        tab[7]  = '{1'b1, 1'b1, 4'b0000, 8,   0, 0, 4'h1, 4'h0};
        tab[8]  = '{1'b1, 1'b1, 4'b0010, 2,   0, 0, 4'h1, 4'h0};
        tab[9]  = '{1'b1, 1'b1, 4'b0000, 1,   0, 0, 4'h1, 4'h1};
        tab[10] = '{1'b1, 1'b1, 4'b0010, 20,  1, 0, 4'h2, 4'h3};
        tab[11] = '{1'b1, 1'b1, 4'b0000, 8,   0, 0, 4'h2, 4'h0};
        tab[12] = '{1'b1, 1'b1, 4'b0110, 20,  0, 1, 4'h2, 4'h3};
        tab[13] = '{1'b1, 1'b1, 4'b0000, 8,   0, 0, 4'h2, 4'h0};
        tab[14] = '{1'b1, 1'b1, 4'b1000, 100, 1, 0, 4'h8, 4'h3};
        tab[15] = '{1'b1, 1'b1, 4'b0000, 8,   0, 0, 4'h8, 4'h0};
        tab[16] = '{1'b1, 1'b0, 4'b0001, 20,  0, 0, 4'h8, 4'h0};

        for (int i = 0; i < 17; i++) begin
            reset  = tab[i].rst;
            enable = tab[i].en;
            chaves = tab[i].ch;
            run(tab[i].n, nf, ni);
            chk($sformatf("seg%0d feita", i), nf, tab[i].feita);
            chk($sformatf("seg%0d invalida", i), ni, tab[i].inv);
            chk($sformatf("seg%0d jogada", i), jogada, tab[i].jog);
            chk($sformatf("seg%0d estado", i), db_estado, tab[i].est);
        end

        // Key already held and synchronized: raising enable starts filtering on the next edge.
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("en_rise feita@%0d", i), jogada_feita, (i == 5));
            if (i == 5) chk("en_rise jogada", jogada, 4'h1);
        end
        chaves = 4'd0;
        run(8, nf, ni);
        chk("en_rise release estado", db_estado, 4'h0);

        // Exact latency of a clean press: pulse in the cycle after edge k+6.
        chaves = 4'b0100;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("clean feita@%0d", i), jogada_feita, (i == 7));
            if (i == 6) chk("clean jogada before", jogada, 4'h1);
            if (i == 7) chk("clean jogada at pulse", jogada, 4'h4);
        end
        chaves = 4'd0;
        run(8, nf, ni);
        chk("clean release estado", db_estado, 4'h0);

        // Reset while filtering a held key; that key must not be accepted afterwards.
        chaves = 4'b0010;
        run(4, nf, ni);
        chk("midrst filtering estado", db_estado, 4'h1);
        reset = 1'b0;
        run(2, nf, ni);
        chk("midrst estado", db_estado, 4'h3);
        chk("midrst feita", nf, 0);
        chk("midrst jogada", jogada, 4'h0);
        reset = 1'b1;
        run(30, nf, ni);
        chk("midrst held feita", nf, 0);
        chk("midrst held estado", db_estado, 4'h3);
        chaves = 4'd0;
        run(8, nf, ni);
        chk("midrst release estado", db_estado, 4'h0);
        chaves = 4'b0001;
        run(20, nf, ni);
        chk("midrst new press feita", nf, 1);
        chk("midrst new press jogada", jogada, 4'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
